// File: rtl/cad_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cad_ctrl_pkg
//   Shared definitions for the compute controller slice: the 3-bit state
//   encoding of the inner sequencer and the default array geometry and
//   MAC pipeline latency used when the top is instantiated without overrides.
// ---------------------------------------------------------------------------
package cad_ctrl_pkg;

    localparam int DEF_NUM_ROWS = 4;
    localparam int DEF_NUM_COLS = 4;
    localparam int DEF_PIPE_LAT = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ROW_INIT = 3'd1,
        ST_READ     = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_WRITE    = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

endpackage

// File: rtl/enable_delay_line.sv
// ---------------------------------------------------------------------------
// enable_delay_line
//   DEPTH-stage shift register for enable/strobe bits. Used to align the
//   accumulate enable with operand data emerging from the memory/MAC pipeline.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset, clears every stage
//   clr    in   1      synchronous clear, flushes every stage at the next edge
//   din    in   WIDTH  value entering stage 0
//   dout   out  WIDTH  value leaving the last stage (din delayed DEPTH cycles)
// ---------------------------------------------------------------------------
module enable_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = '0;
        end
        // A clear flushes everything in flight so no stale enable emerges later.
        if (!clr) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/compute_controller.sv
// ---------------------------------------------------------------------------
// compute_controller
//   Inner sequencer behind the top-level start/done handshake. On inner_start
//   it walks a NUM_ROWS x NUM_COLS operand memory row by row: per row it
//   clears the accumulator, issues NUM_COLS reads, lets the MAC pipeline
//   drain for PIPE_LAT cycles, then writes one result. A single-cycle done
//   follows the last row's write.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   inner_rst    in   1      synchronous clear, overrides everything
//   inner_start  in   1      start pulse, only honoured in IDLE
//   rd_row       out  ROW_W  operand read row (valid with mem_rd_en)
//   rd_col       out  COL_W  operand read column (valid with mem_rd_en)
//   mem_rd_en    out  1      operand read strobe
//   acc_clr      out  1      accumulator clear, one cycle per row
//   mac_en       out  1      accumulate enable, mem_rd_en delayed PIPE_LAT
//   wr_en        out  1      result write strobe
//   wr_addr      out  ROW_W  result address (valid with wr_en)
//   busy         out  1      high whenever not IDLE
//   done         out  1      one-cycle completion pulse
// ---------------------------------------------------------------------------
module compute_controller
    import cad_ctrl_pkg::*;
#(
    parameter  int NUM_ROWS = DEF_NUM_ROWS,
    parameter  int NUM_COLS = DEF_NUM_COLS,
    parameter  int PIPE_LAT = DEF_PIPE_LAT,
    localparam int ROW_W    = $clog2(NUM_ROWS),
    localparam int COL_W    = $clog2(NUM_COLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inner_rst,
    input  logic             inner_start,
    output logic [ROW_W-1:0] rd_row,
    output logic [COL_W-1:0] rd_col,
    output logic             mem_rd_en,
    output logic             acc_clr,
    output logic             mac_en,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_addr,
    output logic             busy,
    output logic             done
);

    // The drain counter needs at least one bit even when PIPE_LAT is 1.
    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(NUM_COLS - 1);
    localparam logic [DRN_W-1:0] DRN_START = DRN_W'(PIPE_LAT - 1);

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q,   row_d;
    logic [COL_W-1:0]   col_q,   col_d;
    logic [DRN_W-1:0]   drain_q, drain_d;

    // -----------------------------------------------------------------------
    // State and counter registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            drain_q <= drain_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and counter logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        drain_d = drain_q;

        unique case (state_q)
            ST_IDLE: begin
                if (inner_start) begin
                    state_d = ST_ROW_INIT;
                    row_d   = '0;
                end
            end

            ST_ROW_INIT: begin
                col_d   = '0;
                state_d = ST_READ;
            end

            ST_READ: begin
                if (col_q == LAST_COL) begin
                    // Column wraps here; the drain count is preloaded so the
                    // first DRAIN cycle already sees PIPE_LAT-1.
                    col_d   = '0;
                    drain_d = DRN_START;
                    state_d = ST_DRAIN;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end

            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_WRITE;
                end else begin
                    drain_d = drain_q - DRN_W'(1);
                end
            end

            ST_WRITE: begin
                if (row_q == LAST_ROW) begin
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = ST_ROW_INIT;
                end
            end

            ST_DONE: begin
                row_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Synchronous clear from the general controller wins over any start
        // or in-flight row.
        if (inner_rst) begin
            state_d = ST_IDLE;
            row_d   = '0;
            col_d   = '0;
            drain_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Moore output decode
    // -----------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        acc_clr   = 1'b0;
        mem_rd_en = 1'b0;
        rd_row    = '0;
        rd_col    = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        done      = 1'b0;

        busy = (state_q != ST_IDLE);

        unique case (state_q)
            ST_ROW_INIT: acc_clr = 1'b1;
            ST_READ: begin
                mem_rd_en = 1'b1;
                rd_row    = row_q;
                rd_col    = col_q;
            end
            ST_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = row_q;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // mac_en is the only registered output: each read strobe re-emerges
    // PIPE_LAT cycles later, so the last one lands on the final DRAIN cycle.
    enable_delay_line #(
        .WIDTH (1),
        .DEPTH (PIPE_LAT)
    ) u_mac_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (inner_rst),
        .din   (mem_rd_en),
        .dout  (mac_en)
    );

endmodule

// File: tb/tb_compute_controller.sv
// ---------------------------------------------------------------------------
// tb_compute_controller
//   Scoreboard bench: each accepted start pushes the full expected event
//   timeline (acc_clr, reads, mac_en, writes, done) into queues; a monitor on
//   the falling edge pops and compares whenever the DUT raises a strobe.
// ---------------------------------------------------------------------------
module tb_compute_controller;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int PL = 2;
    localparam int P  = NC + PL + 2;   // cycles per row

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inner_rst = 1'b0;
    logic       inner_start = 1'b0;
    logic [1:0] rd_row, rd_col, wr_addr;
    logic       mem_rd_en, acc_clr, mac_en, wr_en, busy, done;

    compute_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inner_rst   (inner_rst),
        .inner_start (inner_start),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .mem_rd_en   (mem_rd_en),
        .acc_clr     (acc_clr),
        .mac_en      (mac_en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Cycle n is the interval following the n-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int a;
        int b;
    } ev_t;

    ev_t rd_q[$], mac_q[$], clr_q[$], wr_q[$], done_q[$];

    int busy_from = 1;
    int busy_to   = 0;
    int n_rd = 0, n_mac = 0, n_clr = 0, n_wr = 0, n_done = 0;
    int x_rd = 0, x_mac = 0, x_clr = 0, x_wr = 0, x_done = 0;
    int last_done = -1;
    int last_mac  = -1;
    int errors = 0;
    int checks = 0;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a start sampled at the end of cycle b produces a fixed
    // timeline; row r occupies cycles b+1+r*P .. b+(r+1)*P.
    task automatic model_run(int b);
        busy_from = b + 1;
        busy_to   = b + 1 + NR * P;
        for (int r = 0; r < NR; r++) begin
            clr_q.push_back('{b + 1 + r * P, r, 0});
            x_clr++;
            for (int c = 0; c < NC; c++) begin
                rd_q.push_back('{b + 2 + r * P + c, r, c});
                mac_q.push_back('{b + 2 + r * P + c + PL, 0, 0});
                x_rd++;
                x_mac++;
            end
            wr_q.push_back('{b + 2 + r * P + NC + PL, r, 0});
            x_wr++;
        end
        done_q.push_back('{busy_to, 0, 0});
        x_done++;
    endtask

    // Abort: nothing scheduled after cycle a will appear.
    task automatic purge(int a);
        while (rd_q.size() > 0 && rd_q[$].c > a)     begin void'(rd_q.pop_back());   x_rd--;   end
        while (mac_q.size() > 0 && mac_q[$].c > a)   begin void'(mac_q.pop_back());  x_mac--;  end
        while (clr_q.size() > 0 && clr_q[$].c > a)   begin void'(clr_q.pop_back());  x_clr--;  end
        while (wr_q.size() > 0 && wr_q[$].c > a)     begin void'(wr_q.pop_back());   x_wr--;   end
        while (done_q.size() > 0 && done_q[$].c > a) begin void'(done_q.pop_back()); x_done--; end
        if (busy_to > a) busy_to = a;
    endtask

    // Monitor / scoreboard
    ev_t e;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", int'(busy), int'(cyc >= busy_from && cyc <= busy_to));
            if (acc_clr) begin
                n_clr++;
                if (clr_q.size() == 0) chk("acc_clr_unexpected_cycle", cyc, -1);
                else begin
                    e = clr_q.pop_front();
                    chk("acc_clr_cycle", cyc, e.c);
                end
            end
            if (mem_rd_en) begin
                n_rd++;
                if (rd_q.size() == 0) chk("rd_unexpected_cycle", cyc, -1);
                else begin
                    e = rd_q.pop_front();
                    chk("rd_cycle", cyc, e.c);
                    chk("rd_row", int'(rd_row), e.a);
                    chk("rd_col", int'(rd_col), e.b);
                end
            end
            if (mac_en) begin
                n_mac++;
                last_mac = cyc;
                if (mac_q.size() == 0) chk("mac_unexpected_cycle", cyc, -1);
                else begin
                    e = mac_q.pop_front();
                    chk("mac_cycle", cyc, e.c);
                end
            end
            if (wr_en) begin
                n_wr++;
                if (wr_q.size() == 0) chk("wr_unexpected_cycle", cyc, -1);
                else begin
                    e = wr_q.pop_front();
                    chk("wr_cycle", cyc, e.c);
                    chk("wr_addr", int'(wr_addr), e.a);
                end
            end
            if (done) begin
                n_done++;
                last_done = cyc;
                if (done_q.size() == 0) chk("done_unexpected_cycle", cyc, -1);
                else begin
                    e = done_q.pop_front();
                    chk("done_cycle", cyc, e.c);
                end
            end
        end
    end

    // One cycle of stimulus, called at a falling edge.
    task automatic step(bit st, bit rs);
        int k;
        k = cyc;
        inner_start = st;
        inner_rst   = rs;
        if (rs) purge(k);
        else if (st && k > busy_to) model_run(k);
        @(negedge clk);
    endtask

    task automatic run_seq(int len, int s0, int s1, int s2, int ab);
        for (int i = 0; i < len; i++) begin
            step(i == s0 || i == s1 || i == s2, i == ab);
        end
        inner_start = 1'b0;
        inner_rst   = 1'b0;
    endtask

    task automatic settle();
        int guard;
        guard = 0;
        while (cyc <= busy_to + 1 && guard < 200) begin
            step(1'b0, 1'b0);
            guard++;
        end
    endtask

    task automatic check_end(string tag);
        chk({tag, "_rd_left"},   rd_q.size(),   0);
        chk({tag, "_mac_left"},  mac_q.size(),  0);
        chk({tag, "_clr_left"},  clr_q.size(),  0);
        chk({tag, "_wr_left"},   wr_q.size(),   0);
        chk({tag, "_done_left"}, done_q.size(), 0);
        chk({tag, "_n_clr"},  n_clr,  x_clr);
        chk({tag, "_n_rd"},   n_rd,   x_rd);
        chk({tag, "_n_mac"},  n_mac,  x_mac);
        chk({tag, "_n_wr"},   n_wr,   x_wr);
        chk({tag, "_n_done"}, n_done, x_done);
        n_rd = 0; n_mac = 0; n_clr = 0; n_wr = 0; n_done = 0;
        x_rd = 0; x_mac = 0; x_clr = 0; x_wr = 0; x_done = 0;
        rd_q.delete(); mac_q.delete(); clr_q.delete(); wr_q.delete(); done_q.delete();
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_busy"},      int'(busy),      0);
        chk({tag, "_mem_rd_en"}, int'(mem_rd_en), 0);
        chk({tag, "_acc_clr"},   int'(acc_clr),   0);
        chk({tag, "_mac_en"},    int'(mac_en),    0);
        chk({tag, "_wr_en"},     int'(wr_en),     0);
        chk({tag, "_done"},      int'(done),      0);
        chk({tag, "_rd_row"},    int'(rd_row),    0);
        chk({tag, "_rd_col"},    int'(rd_col),    0);
        chk({tag, "_wr_addr"},   int'(wr_addr),   0);
    endtask

    initial begin
        int b;
        int s1, s2, ab, gap;

        // Power-on reset
        repeat (3) @(negedge clk);
        #1 check_all_zero("por");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_seq(6, -1, -1, -1, -1);
        check_end("idle");

        // Full run
        b = cyc;
        run_seq(40, 0, -1, -1, -1);
        chk("full_done_cycle", last_done, b + 33);
        check_end("full");

        // Starts while busy are ignored
        b = cyc;
        run_seq(40, 0, 5, 20, -1);
        chk("busy_start_done_cycle", last_done, b + 33);
        check_end("busy_start");

        // Synchronous abort in row 1 READ, then a clean run
        b = cyc;
        last_mac = -1;
        run_seq(24, 0, -1, -1, 12);
        chk("abort_last_mac_ok", int'(last_mac <= b + 14), 1);
        settle();
        check_end("abort");
        b = cyc;
        run_seq(40, 0, -1, -1, -1);
        chk("after_abort_done_cycle", last_done, b + 33);
        check_end("after_abort");

        // Back-to-back runs
        b = cyc;
        run_seq(70, 0, 34, -1, -1);
        chk("b2b_done_cycle", last_done, b + 67);
        check_end("b2b");

        // Start in the DONE cycle is ignored
        b = cyc;
        run_seq(40, 0, 33, -1, -1);
        chk("done_cycle_start_ignored_busy", int'(busy), 0);
        check_end("start_in_done");

        // Randomised runs with stray starts and optional aborts
        for (int it = 0; it < 8; it++) begin
            gap = $urandom_range(0, 3);
            run_seq(gap, -1, -1, -1, -1);
            s1 = $urandom_range(1, 45);
            s2 = $urandom_range(1, 60);
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 50)) : -1;
            run_seq(62, 0, s1, s2, ab);
            settle();
            check_end("rand");
        end

        // Asynchronous reset in the middle of row 0 READ
        run_seq(4, 0, -1, -1, -1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        purge(cyc - 1);
        #1 check_all_zero("async_rst");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_seq(12, -1, -1, -1, -1);
        chk("post_rst_busy", int'(busy), 0);
        check_end("async_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
